pllcfg_err_avm_writer: RTL

// Avalon-MM initiator that delivers PLL-reconfiguration error codes to an 8-bit
// PIO-style error register (write at word address ERR_ADDR, data in bits [7:0]).

---
 rtl/pllcfg_err_avm_writer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pllcfg_err_avm_writer.sv
// Avalon-MM initiator: queues PLL-reconfig error codes and writes each one,
// in arrival order, to an 8-bit error register at word address ERR_ADDR.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   err_valid         one-cycle strobe, err_code is a new event
//   err_code[7:0]     error code to deliver
//   avm_*             Avalon-MM initiator (address, chipselect, write_n,
//                     read_n, writedata, readdata, waitrequest)
//   fifo_level        entries currently queued
//   drop_cnt          events lost to a full queue, saturates at 255
//   busy              engine active or queue non-empty
//   verify_err        sticky readback mismatch
//
// Optional feature: define PLLCFG_ERR_READBACK_EN to read the register back
// after every write and compare it against the code that was written.
module pllcfg_err_avm_writer #(
  parameter int ADDR_W     = 2,
  parameter int ERR_ADDR   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          err_valid,
  input  logic [7:0]                    err_code,
  output logic [ADDR_W-1:0]             avm_address,
  output logic                          avm_chipselect,
  output logic                          avm_write_n,
  output logic                          avm_read_n,
  output logic [31:0]                   avm_writedata,
  input  logic [31:0]                   avm_readdata,
  input  logic                          avm_waitrequest,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt,
  output logic                          busy,
  output logic                          verify_err
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
`ifdef PLLCFG_ERR_READBACK_EN
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
`endif

  logic [2:0]    state;
  logic [7:0]    code;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          full;
  logic          unused_rdata;

  assign full = (fifo_level == (PW+1)'(FIFO_DEPTH));
  assign pop  = (state == S_IDLE) && (fifo_level != '0);
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign push = err_valid && (!full || pop);

  assign avm_address = ADDR_W'(ERR_ADDR);
  assign busy        = (state != S_IDLE) || (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= err_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (PW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (PW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (err_valid && !push && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef PLLCFG_ERR_READBACK_EN
  logic [7:0] rd_cap;
  logic       rd_n_q;
  logic       verr_q;

  assign avm_read_n   = rd_n_q;
  assign verify_err   = verr_q;
  assign unused_rdata = ^avm_readdata[31:8];
`else
  assign avm_read_n   = 1'b1;
  assign verify_err   = 1'b0;
  assign unused_rdata = ^avm_readdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      code           <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
`ifdef PLLCFG_ERR_READBACK_EN
      rd_cap         <= '0;
      rd_n_q         <= 1'b1;
      verr_q         <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            code  <= mem[rd_ptr];
            state <= S_POP;
          end
        end
        S_POP: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_writedata  <= {24'b0, code};
          state          <= S_WRITE;
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            avm_write_n <= 1'b1;
`ifdef PLLCFG_ERR_READBACK_EN
            // chipselect stays up; the read follows directly.
            rd_n_q      <= 1'b0;
            state       <= S_READ;
`else
            avm_chipselect <= 1'b0;
            state          <= S_IDLE;
`endif
          end
        end
`ifdef PLLCFG_ERR_READBACK_EN
        S_READ: begin
          if (!avm_waitrequest) begin
            avm_chipselect <= 1'b0;
            rd_n_q         <= 1'b1;
            rd_cap         <= avm_readdata[7:0];
            state          <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (rd_cap != code) verr_q <= 1'b1;
          state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
